// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with a two-stage read/modify/write pipeline, ECALL/MRET trap handling and illegal-access detection.
// Latency: csr_rdata, out_csr_cmd, illegal, redirect_valid and redirect_pc are registered one cycle after the command; CSR state updates one cycle later again.
// Backpressure: none. A command is accepted every cycle, and flush turns that cycle's command into a no-op.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   flush                       squash this cycle's command (treated as CSR_X)
//   csr_cmd[2:0]                X=0 W=1 S=2 C=3 ECALL=4 MRET=5
//   csr_addr[11:0]              CSR address (ignored for ECALL/MRET)
//   op1_data[XLEN-1:0]          write/set/clear operand
//   pc[XLEN-1:0]                PC of the commanding instruction (saved to mepc on ECALL)
//   instr_retire                one instruction retired this cycle
//   csr_rdata[XLEN-1:0]         registered read data
//   out_csr_cmd[2:0]            registered effective command
//   illegal                     registered illegal-access flag
//   redirect_valid/redirect_pc  registered fetch redirect for ECALL (mtvec) / MRET (mepc)
//   trap_vector[XLEN-1:0]       current mtvec
//
// Optional feature macro: CSR_COUNTERS_EN. It implements mcycle/mcycleh/minstret/minstreth.
// Without it those addresses are unimplemented and instr_retire is ignored.
// The counter halves are 32 bits wide, so XLEN is expected to be 32 when counters are enabled.

module csr_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter int unsigned     HART_ID     = 0,
    parameter int unsigned     COUNTER_W   = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic [2:0]      csr_cmd,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] op1_data,
    input  logic [XLEN-1:0] pc,
    input  logic            instr_retire,
    output logic [XLEN-1:0] csr_rdata,
    output logic [2:0]      out_csr_cmd,
    output logic            illegal,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] trap_vector
);

    localparam logic [2:0] CMD_X     = 3'd0;
    localparam logic [2:0] CMD_W     = 3'd1;
    localparam logic [2:0] CMD_S     = 3'd2;
    localparam logic [2:0] CMD_C     = 3'd3;
    localparam logic [2:0] CMD_ECALL = 3'd4;
    localparam logic [2:0] CMD_MRET  = 3'd5;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MHARTID   = 12'hF14;
`ifdef CSR_COUNTERS_EN
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;

    // The counters are always held in 64 bits. A 32-bit build masks the
    // upper word so the counters wrap at 2^32 and the high halves stay 0.
    localparam bit          CNT_HI   = (COUNTER_W == 64);
    localparam logic [63:0] CNT_MASK = CNT_HI ? 64'hFFFF_FFFF_FFFF_FFFF
                                              : 64'h0000_0000_FFFF_FFFF;
`endif

    localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);

    // ------------------------------------------------------------------
    // Stage 1: effective command
    // ------------------------------------------------------------------
    logic [2:0] cmd_e;
    logic       rmw1;

    assign cmd_e = flush ? CMD_X : csr_cmd;
    assign rmw1  = (cmd_e == CMD_W) || (cmd_e == CMD_S) || (cmd_e == CMD_C);

    // ------------------------------------------------------------------
    // Pipeline and architectural registers
    // ------------------------------------------------------------------
    logic [2:0]      cmd2_q;
    logic [11:0]     addr2_q;
    logic [XLEN-1:0] op2_q;
    logic [XLEN-1:0] pc2_q;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            ill_q, ill_d;
    logic            rvld_q, rvld_d;
    logic [XLEN-1:0] rpc_q, rpc_d;

    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;

    // ------------------------------------------------------------------
    // Stage 2: write-back value
    // "old" is the value returned by stage 1. That value was already
    // bypassed, so back-to-back RMWs on one CSR chain correctly.
    // ------------------------------------------------------------------
    logic            wr2;
    logic [XLEN-1:0] wval;

    assign wr2 = ((cmd2_q == CMD_W) || (cmd2_q == CMD_S) || (cmd2_q == CMD_C)) && !ill_q;

    always_comb begin
        wval = op2_q;
        case (cmd2_q)
            CMD_S:   wval = rdata_q | op2_q;
            CMD_C:   wval = rdata_q & ~op2_q;
            default: wval = op2_q;
        endcase
    end

    // Next state of the trap/scratch CSRs. The ECALL/MRET effects are
    // applied after the software write. Only one of the two can be in
    // stage 2 in a given cycle, so they never actually collide.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (wr2) begin
            case (addr2_q)
                A_MSTATUS: begin
                    mie_d  = wval[3];
                    mpie_d = wval[7];
                end
                A_MTVEC:    mtvec_d    = {wval[XLEN-1:2], 2'b00};
                A_MSCRATCH: mscratch_d = wval;
                A_MEPC:     mepc_d     = {wval[XLEN-1:2], 2'b00};
                A_MCAUSE:   mcause_d   = wval;
                default: ;
            endcase
        end
        if (cmd2_q == CMD_ECALL) begin
            mepc_d   = {pc2_q[XLEN-1:2], 2'b00};
            mcause_d = CAUSE_ECALL;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (cmd2_q == CMD_MRET) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

`ifdef CSR_COUNTERS_EN
    // ------------------------------------------------------------------
    // Counters. A software write to either half replaces the whole
    // counter for that cycle. The half that is not written keeps its
    // current value and the increment is skipped.
    // ------------------------------------------------------------------
    logic [63:0] mcycle_q, mcycle_d, mcycle_v;
    logic [63:0] minstret_q, minstret_d, minstret_v;
    logic        cyc_wr, ret_wr;

    always_comb begin
        mcycle_d   = (mcycle_q + 64'd1) & CNT_MASK;
        minstret_d = (minstret_q + {63'd0, instr_retire}) & CNT_MASK;
        cyc_wr     = 1'b0;
        ret_wr     = 1'b0;
        if (wr2) begin
            case (addr2_q)
                A_MCYCLE: begin
                    mcycle_d = {mcycle_q[63:32], wval[31:0]};
                    cyc_wr   = 1'b1;
                end
                A_MCYCLEH: begin
                    mcycle_d = {wval[31:0], mcycle_q[31:0]};
                    cyc_wr   = 1'b1;
                end
                A_MINSTRET: begin
                    minstret_d = {minstret_q[63:32], wval[31:0]};
                    ret_wr     = 1'b1;
                end
                A_MINSTRETH: begin
                    minstret_d = {wval[31:0], minstret_q[31:0]};
                    ret_wr     = 1'b1;
                end
                default: ;
            endcase
        end
        // Reads see a pending software write, but not the increment
        // that is in progress.
        mcycle_v   = cyc_wr ? mcycle_d : mcycle_q;
        minstret_v = ret_wr ? minstret_d : minstret_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`else
    logic unused_retire;
    assign unused_retire = instr_retire;
`endif

    // ------------------------------------------------------------------
    // Stage 1 read mux. Trap/scratch CSRs are read from their next-state
    // value, so a stage-2 write (or ECALL/MRET) is visible at once.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rd_val;
    logic            rd_impl;

    always_comb begin
        rd_val  = '0;
        rd_impl = 1'b1;
        case (csr_addr)
            A_MSTATUS: begin
                rd_val[3] = mie_d;
                rd_val[7] = mpie_d;
            end
            A_MTVEC:     rd_val = mtvec_d;
            A_MSCRATCH:  rd_val = mscratch_d;
            A_MEPC:      rd_val = mepc_d;
            A_MCAUSE:    rd_val = mcause_d;
            A_MHARTID:   rd_val = XLEN'(HART_ID);
`ifdef CSR_COUNTERS_EN
            A_MCYCLE:    rd_val = XLEN'(mcycle_v[31:0]);
            A_MINSTRET:  rd_val = XLEN'(minstret_v[31:0]);
            A_MCYCLEH: begin
                rd_val  = XLEN'(mcycle_v[63:32]);
                rd_impl = CNT_HI;
            end
            A_MINSTRETH: begin
                rd_val  = XLEN'(minstret_v[63:32]);
                rd_impl = CNT_HI;
            end
`endif
            default:     rd_impl = 1'b0;
        endcase
    end

    // An access is illegal if the address is unimplemented, or if it would
    // change mhartid. A set/clear with a zero mask is a pure read and is
    // allowed.
    always_comb begin
        ill_d = 1'b0;
        if (rmw1) begin
            if (!rd_impl) begin
                ill_d = 1'b1;
            end else if (csr_addr == A_MHARTID) begin
                ill_d = !(((cmd_e == CMD_S) || (cmd_e == CMD_C)) && (op1_data == '0));
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        rvld_d  = 1'b0;
        rpc_d   = '0;
        if (cmd_e == CMD_ECALL) begin
            rdata_d = CAUSE_ECALL;
            rvld_d  = 1'b1;
            // mtvec as currently registered. A write in stage 2 this
            // cycle is not forwarded to the trap target.
            rpc_d   = mtvec_q;
        end else if (cmd_e == CMD_MRET) begin
            rvld_d  = 1'b1;
            // A stage-2 mepc update (software write or ECALL) is forwarded.
            rpc_d   = mepc_d;
        end else if (rmw1 && !ill_d) begin
            rdata_d = rd_val;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd2_q     <= CMD_X;
            addr2_q    <= '0;
            op2_q      <= '0;
            pc2_q      <= '0;
            rdata_q    <= '0;
            ill_q      <= 1'b0;
            rvld_q     <= 1'b0;
            rpc_q      <= '0;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= {MTVEC_RESET[XLEN-1:2], 2'b00};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            cmd2_q     <= cmd_e;
            addr2_q    <= csr_addr;
            op2_q      <= op1_data;
            pc2_q      <= pc;
            rdata_q    <= rdata_d;
            ill_q      <= ill_d;
            rvld_q     <= rvld_d;
            rpc_q      <= rpc_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    // The low bits of the saved PC are dropped when mepc is written.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^pc2_q[1:0];

    assign csr_rdata      = rdata_q;
    assign out_csr_cmd    = cmd2_q;
    assign illegal        = ill_q;
    assign redirect_valid = rvld_q;
    assign redirect_pc    = rpc_q;
    assign trap_vector    = mtvec_q;

endmodule
